// File: rtl/qcm_pkg.sv
// Shared types for the global-phase datapath: literal codes, power-of-i type
// and the phase-from-amplitude FSM state encoding.
package qcm_pkg;

  localparam logic [1:0] LIT_I = 2'd0;
  localparam logic [1:0] LIT_X = 2'd1;
  localparam logic [1:0] LIT_Z = 2'd2;
  localparam logic [1:0] LIT_Y = 2'd3;

  typedef logic [1:0] ipow_t;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_SCAN    = 2'd1,
    PH_RESOLVE = 2'd2
  } ph_state_e;

  // Exponent difference of two powers of i, wrapping mod 4.
  function automatic ipow_t ipow_sub(input ipow_t a, input ipow_t b);
    return ipow_t'(a - b);
  endfunction

endpackage

// File: rtl/amp_ipow_decode.sv
// Maps a target amplitude in {+1,+i,-1,-i} to its power of i; anything else
// (including zero) is flagged as not representable.
module amp_ipow_decode
  import qcm_pkg::*;
(
  input  logic signed [31:0] target_r_i,
  input  logic signed [31:0] target_i_i,
  output ipow_t              k_o,
  output logic               bad_o
);

  // Decode the four unit amplitudes.
  always_comb begin
    k_o   = 2'd0;
    bad_o = 1'b0;
    if (target_r_i == 32'sd1 && target_i_i == 32'sd0) begin
      k_o = 2'd0;
    end else if (target_r_i == 32'sd0 && target_i_i == 32'sd1) begin
      k_o = 2'd1;
    end else if (target_r_i == -32'sd1 && target_i_i == 32'sd0) begin
      k_o = 2'd2;
    end else if (target_r_i == 32'sd0 && target_i_i == -32'sd1) begin
      k_o = 2'd3;
    end else begin
      bad_o = 1'b1;
    end
  end

endmodule

// File: rtl/fsm_phase_from_amplitude.sv
// Resolves the sign bit of stabilizer row Q so that (-1)^phase * i^nY matches
// a target amplitude, counting Y literals by rotating Q through a full turn.
module fsm_phase_from_amplitude
  import qcm_pkg::*;
#(
  parameter int num_qubit = 4
) (
  input  logic                      clk,
  input  logic                      rst_new,
  input  logic                      determine_phase,
  input  logic signed [31:0]        target_r,
  input  logic signed [31:0]        target_i,
  input  logic [num_qubit-1:0][1:0] reg_literals_Q,
  input  logic                      reg_phase_Q,
  output logic                      ld_Q_rotateLeft,
  output logic                      ld_Q_writePhase,
  output logic                      phase_out,
  output logic                      phase_changed,
  output logic                      phase_error,
  output logic [1:0]                y_count,
  output logic                      done_phase
);

  localparam logic [31:0] CNT_INIT = 32'(num_qubit - 1);

  ph_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  ipow_t       k_q, k_d, y_acc_q, y_acc_d;
  logic        bad_q, bad_d;
  logic        phase_out_q, phase_out_d, phase_changed_q, phase_changed_d;
  logic        phase_error_q, phase_error_d, done_q, done_d;
  logic [1:0]  y_count_q, y_count_d;
  logic        rot_s, wr_s, is_y_s, dec_bad_s;
  ipow_t       dec_k_s, diff_s;
  logic        unused_lits_s;

  amp_ipow_decode u_decode (
    .target_r_i (target_r),
    .target_i_i (target_i),
    .k_o        (dec_k_s),
    .bad_o      (dec_bad_s)
  );

  // Only slot 0 is inspected; the rest of Q reaches it through rotation.
  assign is_y_s        = (reg_literals_Q[0] == LIT_Y);
  assign unused_lits_s = ^reg_literals_Q;
  assign diff_s        = ipow_sub(k_q, y_acc_q);

  // Next-state and Mealy load-enable logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    k_d             = k_q;
    bad_d           = bad_q;
    y_acc_d         = y_acc_q;
    phase_out_d     = phase_out_q;
    phase_changed_d = phase_changed_q;
    phase_error_d   = phase_error_q;
    y_count_d       = y_count_q;
    done_d          = 1'b0;
    rot_s           = 1'b0;
    wr_s            = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (determine_phase) begin
          k_d     = dec_k_s;
          bad_d   = dec_bad_s;
          y_acc_d = {1'b0, is_y_s};
          cnt_d   = CNT_INIT;
          rot_s   = 1'b1;
          state_d = (num_qubit > 1) ? PH_SCAN : PH_RESOLVE;
        end else begin
          state_d = PH_IDLE;
        end
      end
      PH_SCAN: begin
        if (cnt_q > 32'd0) begin
          rot_s   = 1'b1;
          y_acc_d = ipow_t'(y_acc_q + {1'b0, is_y_s});
          cnt_d   = cnt_q - 32'd1;
          state_d = (cnt_q == 32'd1) ? PH_RESOLVE : PH_SCAN;
        end else begin
          state_d = PH_RESOLVE;
        end
      end
      PH_RESOLVE: begin
        // An odd residual needs a factor of i that a sign bit cannot supply.
        if (bad_q || diff_s[0]) begin
          phase_error_d = 1'b1;
        end else begin
          phase_out_d     = diff_s[1];
          phase_changed_d = diff_s[1] ^ reg_phase_Q;
          phase_error_d   = 1'b0;
          wr_s            = 1'b1;
        end
        y_count_d = y_acc_q;
        done_d    = 1'b1;
        state_d   = PH_IDLE;
      end
      default: begin
        state_d = PH_IDLE;
      end
    endcase
  end

  // Reset takes priority over any load in the same cycle.
  assign ld_Q_rotateLeft = rot_s & ~rst_new;
  assign ld_Q_writePhase = wr_s & ~rst_new;

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_new) begin
      state_q         <= PH_IDLE;
      cnt_q           <= 32'd0;
      k_q             <= 2'd0;
      bad_q           <= 1'b0;
      y_acc_q         <= 2'd0;
      phase_out_q     <= 1'b0;
      phase_changed_q <= 1'b0;
      phase_error_q   <= 1'b0;
      y_count_q       <= 2'd0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      k_q             <= k_d;
      bad_q           <= bad_d;
      y_acc_q         <= y_acc_d;
      phase_out_q     <= phase_out_d;
      phase_changed_q <= phase_changed_d;
      phase_error_q   <= phase_error_d;
      y_count_q       <= y_count_d;
      done_q          <= done_d;
    end
  end

  assign phase_out     = phase_out_q;
  assign phase_changed = phase_changed_q;
  assign phase_error   = phase_error_q;
  assign y_count       = y_count_q;
  assign done_phase    = done_q;

endmodule

// File: tb/tb_fsm_phase_from_amplitude.sv
// Randomized and directed bench for fsm_phase_from_amplitude with a model of
// row Q (literal rotation, sign register) and an amplitude-based reference.
module tb_fsm_phase_from_amplitude;

  localparam int NQ = 4;

  logic              clk = 1'b0;
  logic              rst_new = 1'b0;
  logic              determine_phase = 1'b0;
  logic signed [31:0] target_r = 32'sd0;
  logic signed [31:0] target_i = 32'sd0;
  logic [NQ-1:0][1:0] reg_literals_Q = '0;
  logic              reg_phase_Q = 1'b0;
  logic              ld_Q_rotateLeft, ld_Q_writePhase;
  logic              phase_out, phase_changed, phase_error, done_phase;
  logic [1:0]        y_count;

  fsm_phase_from_amplitude #(.num_qubit(NQ)) dut (
    .clk             (clk),
    .rst_new         (rst_new),
    .determine_phase (determine_phase),
    .target_r        (target_r),
    .target_i        (target_i),
    .reg_literals_Q  (reg_literals_Q),
    .reg_phase_Q     (reg_phase_Q),
    .ld_Q_rotateLeft (ld_Q_rotateLeft),
    .ld_Q_writePhase (ld_Q_writePhase),
    .phase_out       (phase_out),
    .phase_changed   (phase_changed),
    .phase_error     (phase_error),
    .y_count         (y_count),
    .done_phase      (done_phase)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Row Q model
  logic [1:0] lits[NQ];
  logic       qph;

  // Observations of the last operation
  int n_rot, n_wr, n_done, first_rot, last_rot, wr_cyc, done_cyc;

  task automatic load_q(input logic [7:0] packed_lits, input logic ph);
    for (int i = 0; i < NQ; i++) lits[i] = packed_lits[2*i +: 2];
    qph = ph;
  endtask

  // Reference: amplitude i^nY via repeated multiplication by i, then match
  // target against +amp (phase 0) or -amp (phase 1).
  task automatic model(input int tr, input int ti, output bit err, output bit ph, output int ny);
    int ar, ai, t;
    ny = 0;
    for (int i = 0; i < NQ; i++) if (lits[i] == 2'd3) ny++;
    ar = 1; ai = 0;
    repeat (ny) begin t = ar; ar = -ai; ai = t; end
    if (tr == ar && ti == ai) begin err = 1'b0; ph = 1'b0; end
    else if (tr == -ar && ti == -ai) begin err = 1'b0; ph = 1'b1; end
    else begin err = 1'b1; ph = 1'b0; end
  endtask

  // Drives one operation cycle by cycle (cycle 0 = start), emulating row Q.
  task automatic run_op(input int tr, input int ti, input int rst_cyc,
                        input int restart_cyc, input int want_done, input int limit);
    logic rot, wr;
    logic [1:0] tmp;
    n_rot = 0; n_wr = 0; n_done = 0;
    first_rot = -1; last_rot = -1; wr_cyc = -1; done_cyc = -1;
    @(negedge clk);
    for (int c = 0; c < limit; c++) begin
      target_r = tr; target_i = ti;
      determine_phase = (c == 0) || (c == restart_cyc);
      rst_new = (c == rst_cyc);
      for (int i = 0; i < NQ; i++) reg_literals_Q[i] = lits[i];
      reg_phase_Q = qph;
      #1;
      rot = ld_Q_rotateLeft;
      wr  = ld_Q_writePhase;
      if (rot) begin n_rot++; if (first_rot < 0) first_rot = c; last_rot = c; end
      if (wr) begin n_wr++; wr_cyc = c; end
      if (done_phase) begin n_done++; done_cyc = c; end
      @(posedge clk);
      #1;
      if (rot) begin
        tmp = lits[0];
        for (int i = 0; i < NQ - 1; i++) lits[i] = lits[i+1];
        lits[NQ-1] = tmp;
      end
      if (wr) qph = phase_out;
      if (n_done >= want_done) break;
      @(negedge clk);
    end
    determine_phase = 1'b0;
    rst_new = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_new = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total += 6;
    if (phase_out !== 1'b0) begin bad++; $display("FAIL rst_phase_out: got %b want 0", phase_out); end
    if (phase_changed !== 1'b0) begin bad++; $display("FAIL rst_phase_changed: got %b want 0", phase_changed); end
    if (phase_error !== 1'b0) begin bad++; $display("FAIL rst_phase_error: got %b want 0", phase_error); end
    if (y_count !== 2'd0) begin bad++; $display("FAIL rst_y_count: got %0d want 0", y_count); end
    if (done_phase !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done_phase); end
    if (ld_Q_writePhase !== 1'b0) begin bad++; $display("FAIL rst_ld_write: got %b want 0", ld_Q_writePhase); end
    // start together with reset: reset wins
    determine_phase = 1'b1;
    target_r = 32'sd1; target_i = 32'sd0;
    #1;
    total++;
    if (ld_Q_rotateLeft !== 1'b0) begin bad++; $display("FAIL rst_start_rotate: got %b want 0", ld_Q_rotateLeft); end
    @(negedge clk);
    determine_phase = 1'b0;
    rst_new = 1'b0;
    #1;
    total++;
    if (ld_Q_rotateLeft !== 1'b0) begin bad++; $display("FAIL rst_start_nostate: got %b want 0", ld_Q_rotateLeft); end
  endtask

  task automatic test_identity();
    load_q(8'h00, 1'b0);
    run_op(1, 0, -1, -1, 1, 20);
    total += 8;
    if (n_rot !== 4 || first_rot !== 0 || last_rot !== 3) begin bad++; $display("FAIL id_rotates: got n=%0d first=%0d last=%0d want 4/0/3", n_rot, first_rot, last_rot); end
    if (wr_cyc !== 4) begin bad++; $display("FAIL id_write_cycle: got %0d want 4", wr_cyc); end
    if (n_wr !== 1) begin bad++; $display("FAIL id_write_count: got %0d want 1", n_wr); end
    if (done_cyc !== 5) begin bad++; $display("FAIL id_done_cycle: got %0d want 5", done_cyc); end
    if (phase_out !== 1'b0) begin bad++; $display("FAIL id_phase_out: got %b want 0", phase_out); end
    if (y_count !== 2'd0) begin bad++; $display("FAIL id_y_count: got %0d want 0", y_count); end
    if (phase_error !== 1'b0) begin bad++; $display("FAIL id_error: got %b want 0", phase_error); end
    if (phase_changed !== 1'b0) begin bad++; $display("FAIL id_changed: got %b want 0", phase_changed); end
  endtask

  task automatic test_single_y();
    load_q(8'h03, 1'b0);
    run_op(0, 1, -1, -1, 1, 20);
    total += 3;
    if (phase_out !== 1'b0) begin bad++; $display("FAIL y1_plus_i_phase: got %b want 0", phase_out); end
    if (phase_error !== 1'b0) begin bad++; $display("FAIL y1_plus_i_error: got %b want 0", phase_error); end
    if (y_count !== 2'd1) begin bad++; $display("FAIL y1_y_count: got %0d want 1", y_count); end
    load_q(8'h03, 1'b0);
    run_op(0, -1, -1, -1, 1, 20);
    total += 2;
    if (phase_out !== 1'b1) begin bad++; $display("FAIL y1_minus_i_phase: got %b want 1", phase_out); end
    if (phase_changed !== 1'b1) begin bad++; $display("FAIL y1_minus_i_changed: got %b want 1", phase_changed); end
  endtask

  task automatic test_two_y();
    load_q(8'h9F, 1'b0);
    run_op(-1, 0, -1, -1, 1, 20);
    total += 3;
    if (y_count !== 2'd2) begin bad++; $display("FAIL y2_y_count: got %0d want 2", y_count); end
    if (phase_out !== 1'b0) begin bad++; $display("FAIL y2_minus1_phase: got %b want 0", phase_out); end
    if (lits[0] !== 2'd3 || lits[1] !== 2'd3 || lits[2] !== 2'd1 || lits[3] !== 2'd2) begin
      bad++; $display("FAIL y2_order_restored: got %0d%0d%0d%0d want 3312", lits[0], lits[1], lits[2], lits[3]);
    end
    load_q(8'h9F, 1'b0);
    run_op(1, 0, -1, -1, 1, 20);
    total++;
    if (phase_out !== 1'b1) begin bad++; $display("FAIL y2_plus1_phase: got %b want 1", phase_out); end
  endtask

  task automatic test_odd();
    load_q(8'h03, 1'b0);
    run_op(1, 0, -1, -1, 1, 20);
    total += 4;
    if (phase_error !== 1'b1) begin bad++; $display("FAIL odd_error: got %b want 1", phase_error); end
    if (n_wr !== 0) begin bad++; $display("FAIL odd_no_write: got %0d writes want 0", n_wr); end
    if (done_cyc !== 5) begin bad++; $display("FAIL odd_done: got %0d want 5", done_cyc); end
    if (phase_out !== 1'b1) begin bad++; $display("FAIL odd_phase_held: got %b want 1", phase_out); end
  endtask

  task automatic test_bad_target();
    load_q(8'h00, 1'b0);
    run_op(0, 0, -1, -1, 1, 20);
    total += 2;
    if (phase_error !== 1'b1) begin bad++; $display("FAIL zero_error: got %b want 1", phase_error); end
    if (n_rot !== 4) begin bad++; $display("FAIL zero_rotates: got %0d want 4", n_rot); end
    run_op(2, 0, -1, -1, 1, 20);
    total += 2;
    if (phase_error !== 1'b1) begin bad++; $display("FAIL two_error: got %b want 1", phase_error); end
    if (n_rot !== 4) begin bad++; $display("FAIL two_rotates: got %0d want 4", n_rot); end
  endtask

  task automatic test_reset_mid();
    load_q(8'h03, 1'b0);
    run_op(0, 1, 2, -1, 1, 12);
    total += 6;
    if (n_rot !== 2) begin bad++; $display("FAIL midrst_rotates: got %0d want 2", n_rot); end
    if (n_done !== 0 || n_wr !== 0) begin bad++; $display("FAIL midrst_pulses: got done=%0d wr=%0d want 0/0", n_done, n_wr); end
    if (phase_out !== 1'b0) begin bad++; $display("FAIL midrst_phase_out: got %b want 0", phase_out); end
    if (phase_error !== 1'b0) begin bad++; $display("FAIL midrst_error: got %b want 0", phase_error); end
    if (y_count !== 2'd0) begin bad++; $display("FAIL midrst_y_count: got %0d want 0", y_count); end
    if (phase_changed !== 1'b0) begin bad++; $display("FAIL midrst_changed: got %b want 0", phase_changed); end
  endtask

  task automatic test_restart_ignored();
    load_q(8'h00, 1'b0);
    run_op(-1, 0, -1, 2, 1, 20);
    total += 3;
    if (n_rot !== 4) begin bad++; $display("FAIL restart_rotates: got %0d want 4", n_rot); end
    if (done_cyc !== 5) begin bad++; $display("FAIL restart_done: got %0d want 5", done_cyc); end
    if (phase_out !== 1'b1) begin bad++; $display("FAIL restart_phase: got %b want 1", phase_out); end
  endtask

  task automatic test_back_to_back();
    load_q(8'h03, 1'b0);
    run_op(0, -1, -1, 5, 2, 30);
    total += 5;
    if (n_done !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    if (done_cyc !== 10) begin bad++; $display("FAIL b2b_done_cycle: got %0d want 10", done_cyc); end
    if (n_rot !== 8) begin bad++; $display("FAIL b2b_rotates: got %0d want 8", n_rot); end
    if (phase_out !== 1'b1) begin bad++; $display("FAIL b2b_phase: got %b want 1", phase_out); end
    if (phase_changed !== 1'b0) begin bad++; $display("FAIL b2b_changed: got %b want 0", phase_changed); end
  endtask

  task automatic test_random();
    logic [7:0] pl;
    int tr, ti, ny, sel;
    bit err, ph, q0;
    logic exp_po, exp_pc;
    exp_po = 1'b1; exp_pc = 1'b0;  // left by the back-to-back scenario
    for (int it = 0; it < 30; it++) begin
      pl = 8'($urandom);
      q0 = 1'($urandom);
      load_q(pl, q0);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: begin tr = 1;  ti = 0;  end
        1: begin tr = 0;  ti = 1;  end
        2: begin tr = -1; ti = 0;  end
        3: begin tr = 0;  ti = -1; end
        4: begin tr = 0;  ti = 0;  end
        default: begin tr = int'($urandom_range(2, 5)); ti = -1; end
      endcase
      model(tr, ti, err, ph, ny);
      if (!err) begin exp_po = ph; exp_pc = ph ^ q0; end
      run_op(tr, ti, -1, -1, 1, 20);
      total += 6;
      if (phase_error !== err) begin bad++; $display("FAIL rnd%0d_error: got %b want %b", it, phase_error, err); end
      if (phase_out !== exp_po) begin bad++; $display("FAIL rnd%0d_phase: got %b want %b", it, phase_out, exp_po); end
      if (phase_changed !== exp_pc) begin bad++; $display("FAIL rnd%0d_changed: got %b want %b", it, phase_changed, exp_pc); end
      if (y_count !== 2'(ny)) begin bad++; $display("FAIL rnd%0d_y_count: got %0d want %0d", it, y_count, ny % 4); end
      if (n_rot !== 4) begin bad++; $display("FAIL rnd%0d_rotates: got %0d want 4", it, n_rot); end
      if (n_wr !== (err ? 0 : 1) || done_cyc !== 5) begin
        bad++; $display("FAIL rnd%0d_write_done: got wr=%0d done=%0d want %0d/5", it, n_wr, done_cyc, err ? 0 : 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_single_y();
    test_two_y();
    test_odd();
    test_bad_target();
    test_reset_mid();
    test_restart_ignored();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
